// File: rtl/arith_pkg.sv
// Shared definitions for the bit-serial arithmetic cells: FSM encodings and
// the sizing rule for the bit counters.
package arith_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } state_t;

    // Counter width able to hold 0..width.
    function automatic int cnt_bits(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor: x - y - bin, producing difference and borrow-out.
module full_subtractor (
    output logic d,
    output logic bout,
    input  logic x,
    input  logic y,
    input  logic bin
);

    always_comb begin
        d    = x ^ y ^ bin;
        bout = (~x & y) | (~x & bin) | (y & bin);
    end

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: d = (a - b) mod 2^WIDTH, one bit per clock,
// LSB first, with bout set iff a < b.
module serial_subtractor
    import arith_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] d,
    output logic             bout,
    output state_t           state_dbg
);

    // Handshake: start is sampled only in IDLE and captures a/b on that edge;
    // busy covers the WIDTH shift cycles, then done pulses for one cycle with
    // d/bout final. Requests seen while busy or done are dropped, not queued.

    localparam int CW = cnt_bits(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [WIDTH-1:0] sd;
    logic [WIDTH-1:0] sd_shift;
    logic             borrow;
    logic [CW-1:0]    cnt;
    logic             diff;
    logic             bnext;
    logic             last_bit;

    full_subtractor u_cell (
        .d    (diff),
        .bout (bnext),
        .x    (sa[0]),
        .y    (sb[0]),
        .bin  (borrow)
    );

    // New difference bit enters at the MSB; written this way so WIDTH=1 works.
    assign sd_shift  = WIDTH'({diff, sd} >> 1);
    assign last_bit  = (cnt == CNT_LAST);
    assign state_dbg = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_next = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                busy = 1'b1;
                if (last_bit) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                done       = 1'b1;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sa     <= '0;
            sb     <= '0;
            sd     <= '0;
            borrow <= 1'b0;
            cnt    <= '0;
            d      <= '0;
            bout   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        sa     <= a;
                        sb     <= b;
                        sd     <= '0;
                        borrow <= 1'b0;
                        cnt    <= '0;
                    end
                end
                ST_SHIFT: begin
                    sa     <= sa >> 1;
                    sb     <= sb >> 1;
                    sd     <= sd_shift;
                    borrow <= bnext;
                    cnt    <= cnt + CW'(1);
                    // d/bout are holding registers: only the final bit updates them.
                    if (last_bit) begin
                        d    <= sd_shift;
                        bout <= bnext;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
